// File: rtl/tick_debouncer.sv
// Tick-qualified switch debouncer: a new level is accepted after STABLE_TICKS consecutive ticks.
// Optional 2-flop input synchroniser enabled by defining TICK_DEBOUNCER_SYNC_EN.
module tick_debouncer #(
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw,
    output logic db_level,
    output logic db_rise,
    output logic db_fall,
    output logic busy
);

    localparam int CNT_BITS = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STABLE_TICKS - 1);

    generate
        if (STABLE_TICKS < 1) begin : g_bad_param
            $error("tick_debouncer: STABLE_TICKS must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  sw_s;

`ifdef TICK_DEBOUNCER_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
        end
    end

    assign sw_s = sync2_q;
`else
    assign sw_s = sw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A bounce always takes priority over a coincident tick, so the tick is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ZERO: begin
                if (sw_s) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_d = ONE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ZERO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase
    end

    assign rise_d = (state_q == WAIT1) && (state_d == ONE);
    assign fall_d = (state_q == WAIT0) && (state_d == ZERO);

    assign db_level = (state_q == ONE) || (state_q == WAIT0);
    assign busy     = (state_q == WAIT1) || (state_q == WAIT0);
    assign db_rise  = rise_q;
    assign db_fall  = fall_q;

endmodule

// File: doc/tick_debouncer.md
# tick_debouncer

Switch/button debouncer driven by the periodic one-cycle tick of the team's modulus timer (its `done` output). It is the stage directly downstream of that timer. It samples a raw mechanical input and accepts a new level only after the input has held steady for a programmable number of consecutive ticks. It produces a clean level plus single-cycle rise/fall event pulses for downstream control logic.

## Interface
- `STABLE_TICKS`, default 4: consecutive ticks the input must stay at the new level before it is accepted; legal range ≥ 1.
- `CNT_BITS`, localparam = max(1, $clog2(STABLE_TICKS)): width of the tick counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle sample strobe from the timer, same clock domain.
- `sw`  in  1  raw switch input.
- `db_level`  out  1  debounced level.
- `db_rise`  out  1  one-cycle pulse when `db_level` goes 0→1.
- `db_fall`  out  1  one-cycle pulse when `db_level` goes 1→0.
- `busy`  out  1  high while a level change is being qualified.

## Operation
- `sw_s` is the sampled input: `sw` itself, or the synchronised `sw` (see Configuration).
- FSM states: ZERO, WAIT1, ONE, WAIT0. The FSM and counter `cnt` are registered.
- Transitions:
  - ZERO: if `sw_s`=1, go to WAIT1 with `cnt`←0. Otherwise stay.
  - WAIT1:
    - if `sw_s`=0, go to ZERO with `cnt`←0;
    - else if `tick` and `cnt`=STABLE_TICKS−1, go to ONE;
    - else if `tick`, `cnt`←`cnt`+1;
    - else hold.
  - ONE: if `sw_s`=0, go to WAIT0 with `cnt`←0. Otherwise stay.
  - WAIT0: mirror of WAIT1 with polarities swapped. An input bounce returns to ONE; qualification completes into ZERO.
- Outputs:
  - `db_level` = 1 in ONE or WAIT0, 0 in ZERO or WAIT1.
  - `busy` = 1 in WAIT1 or WAIT0.
- `db_rise`/`db_fall` are registered. Each is high for exactly the one cycle in which the state first reads ONE (respectively ZERO) after leaving WAIT1 (respectively WAIT0). Bounce returns (WAIT1→ZERO, WAIT0→ONE) produce no pulse.
- A `tick` arriving in the same cycle the FSM leaves ZERO or ONE is not counted.
- Simultaneous bounce and `tick` in WAIT1/WAIT0: the bounce wins. The FSM returns, `cnt` clears, and the tick is discarded.
- `cnt` never exceeds STABLE_TICKS−1. It has no wrap-around path.
- `tick` held high for several cycles counts once per cycle. This is a legal input, but it is outside the intended use.

## Timing
- Reset (any state, including mid-qualification) takes effect at the next rising edge:
  - state ZERO, `cnt`=0;
  - `db_level`=0, `db_rise`=0, `db_fall`=0, `busy`=0;
  - synchroniser flops = 0.
- Latency from `sw_s` change to `db_level` change is exactly 1 cycle after the STABLE_TICKS-th counted tick.
- For tick period P cycles, that latency is between (STABLE_TICKS−1)·P+2 and STABLE_TICKS·P+1 cycles.
- `db_rise`/`db_fall` are coincident with the first cycle of the new `db_level`.
- Minimum spacing between two events is STABLE_TICKS ticks.

## Configuration
- Macro: `TICK_DEBOUNCER_SYNC_EN`.
- Defined: `sw` passes through a 2-flop synchroniser (reset value 0) before the FSM. `sw_s` lags `sw` by 2 cycles, and every latency above grows by 2 cycles.
- Undefined: `sw_s` = `sw` directly. `sw` must then already be synchronous to `clk`.

## Test plan
All scenarios use STABLE_TICKS=4, tick every 10 cycles, macro undefined.

- **Reset:** `reset` high for 3 cycles with `sw`=1 → `db_level`=0, `db_rise`=0, `db_fall`=0, `busy`=0. After release, WAIT1 is entered on the next edge.
- **Clean press:** `sw` 0→1 held → `busy`=1 one cycle later. `db_level` rises 1 cycle after the 4th counted tick, `db_rise`=1 for exactly that cycle, `busy`=0.
- **Bounce:** `sw` high through 3 ticks, low for 1 cycle, then high → return to ZERO with no `db_rise`. The count restarts, so 4 further ticks are needed before `db_level`=1.
- **Release:** from ONE, `sw` 1→0 held → `db_level` falls after 4 counted ticks, `db_fall` pulses once, and `db_rise` stays 0.
- **Collision:** in WAIT1 with `cnt`=3, `sw`=0 in the same cycle as `tick` → state ZERO, `cnt`=0, no `db_rise`. Separately, reset asserted in WAIT1 with `cnt`=2 → ZERO and all outputs 0 on the next edge.
- **Edge config:** STABLE_TICKS=1 with macro defined → press accepted on the first tick after entering WAIT1, with 2 extra cycles of synchroniser latency.
